// File: rtl/fib_sequencer.sv
// Purpose : sequencing FSM for the 4-bit Fibonacci datapath (init, show term, hold, step, done/fault).
// Latency : start sampled at edge k -> INIT in cycle k+1; each term takes SHOW/WAIT/CHECK/STEP (>=4 cycles).
// Backpressure: waits in WAIT for timer_done_in; a watchdog of WAIT_MAX cycles forces FAULT.
//
// Ports:
//   clock_in, reset_in          clock, async active-high reset
//   start_in                    level start request (IDLE/FAULT only)
//   zero_in, carry_in, b_in     datapath status: count==0, adder carry, B value
//   timer_done_in               display period elapsed (WAIT only)
//   init_out, a_set_out, b_set_out, cnt_set_out, mux_sel_out, timer_start_out
//                               registered datapath/timer controls
//   led_out                     registered displayed term
//   busy_out, done_out, fault_out, ovf_out   status to top level
module fib_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int WAIT_MAX   = 1024
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  zero_in,
  input  logic                  carry_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  timer_done_in,
  output logic                  init_out,
  output logic                  a_set_out,
  output logic                  b_set_out,
  output logic                  cnt_set_out,
  output logic                  mux_sel_out,
  output logic                  timer_start_out,
  output logic [DATA_WIDTH-1:0] led_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  fault_out,
  output logic                  ovf_out
);

  localparam int WD_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SHOW, S_WAIT, S_CHECK, S_STEP, S_DONE, S_FAULT
  } state_t;

  state_t                r_state;
  logic                  r_init;
  logic                  r_a_set;
  logic                  r_b_set;
  logic                  r_cnt_set;
  logic                  r_mux_sel;
  logic                  r_timer_start;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fault;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] r_led;
  logic [WD_W-1:0]       r_wdog;

  // Every output is a flop that is loaded on the edge entering the state it
  // belongs to, so the outputs line up exactly with the state register.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state       <= S_IDLE;
      r_init        <= 1'b0;
      r_a_set       <= 1'b0;
      r_b_set       <= 1'b0;
      r_cnt_set     <= 1'b0;
      r_mux_sel     <= 1'b0;
      r_timer_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_ovf         <= 1'b0;
      r_led         <= '0;
      r_wdog        <= '0;
    end else begin
      r_init        <= 1'b0;
      r_a_set       <= 1'b0;
      r_b_set       <= 1'b0;
      r_cnt_set     <= 1'b0;
      r_mux_sel     <= 1'b0;
      r_timer_start <= 1'b0;
      r_done        <= 1'b0;

      case (r_state)
        S_IDLE, S_FAULT: begin
          if (start_in) begin
            r_state   <= S_INIT;
            r_init    <= 1'b1;
            r_cnt_set <= 1'b1;   // mux_sel stays 0: load the term-count constant
            r_busy    <= 1'b1;
            r_fault   <= 1'b0;
            r_ovf     <= 1'b0;
          end
        end

        S_INIT: begin
          r_state       <= S_SHOW;
          r_timer_start <= 1'b1;
          r_wdog        <= '0;
        end

        S_SHOW: begin
          r_led   <= b_in;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          // Timer completion takes priority over watchdog expiry.
          if (timer_done_in) begin
            r_state <= S_CHECK;
          end else if (r_wdog == WD_LAST) begin
            r_state <= S_FAULT;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end

        S_CHECK: begin
          if (zero_in) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_STEP;
            r_a_set   <= 1'b1;
            r_b_set   <= 1'b1;
            r_cnt_set <= 1'b1;
            r_mux_sel <= 1'b1;
          end
        end

        S_STEP: begin
          // carry_in reflects A+B of the values being stepped this cycle.
          if (carry_in) r_ovf <= 1'b1;
          r_state       <= S_SHOW;
          r_timer_start <= 1'b1;
          r_wdog        <= '0;
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign init_out        = r_init;
  assign a_set_out       = r_a_set;
  assign b_set_out       = r_b_set;
  assign cnt_set_out     = r_cnt_set;
  assign mux_sel_out     = r_mux_sel;
  assign timer_start_out = r_timer_start;
  assign led_out         = r_led;
  assign busy_out        = r_busy;
  assign done_out        = r_done;
  assign fault_out       = r_fault;
  assign ovf_out         = r_ovf;

endmodule

// File: tb/tb_fib_sequencer.sv
module tb_fib_sequencer;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // ---------------- main instance with datapath model ----------------
  logic          rst, start, tdone;
  logic [DW-1:0] n_const;
  logic [DW-1:0] a_q = '0, b_q = '0, cnt_q = '0;
  logic [DW:0]   sum;
  logic          zero, carry;
  logic          init_o, a_set_o, b_set_o, cnt_set_o, mux_o, tstart_o;
  logic          busy_o, done_o, fault_o, ovf_o;
  logic [DW-1:0] led_o;
  logic [DW+9:0] outs;

  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign carry = sum[DW];
  assign zero  = (cnt_q == '0);
  assign outs  = {init_o, a_set_o, b_set_o, cnt_set_o, mux_o, tstart_o,
                  busy_o, done_o, fault_o, ovf_o, led_o};

  fib_sequencer #(.DATA_WIDTH(DW), .WAIT_MAX(16)) dut (
    .clock_in(clk), .reset_in(rst), .start_in(start), .zero_in(zero),
    .carry_in(carry), .b_in(b_q), .timer_done_in(tdone),
    .init_out(init_o), .a_set_out(a_set_o), .b_set_out(b_set_o),
    .cnt_set_out(cnt_set_o), .mux_sel_out(mux_o), .timer_start_out(tstart_o),
    .led_out(led_o), .busy_out(busy_o), .done_out(done_o),
    .fault_out(fault_o), .ovf_out(ovf_o)
  );

  always @(posedge clk) begin
    if (init_o) begin a_q <= '0; b_q <= 4'd1; end
    if (a_set_o) a_q <= b_q;
    if (b_set_o) b_q <= sum[DW-1:0];
    if (cnt_set_o) cnt_q <= mux_o ? (cnt_q - 4'd1) : n_const;
  end

  // ---------------- watchdog instance (WAIT_MAX = 8) ----------------
  logic          wd_start, wd_tdone;
  logic          wd_init, wd_aset, wd_bset, wd_cset, wd_mux, wd_tstart;
  logic          wd_busy, wd_done, wd_fault, wd_ovf;
  logic [DW-1:0] wd_led;
  logic [DW+9:0] wd_outs;
  logic [DW-1:0] wd_b = 4'd1;

  assign wd_outs = {wd_init, wd_aset, wd_bset, wd_cset, wd_mux, wd_tstart,
                    wd_busy, wd_done, wd_fault, wd_ovf, wd_led};

  fib_sequencer #(.DATA_WIDTH(DW), .WAIT_MAX(8)) dut_wd (
    .clock_in(clk), .reset_in(rst), .start_in(wd_start), .zero_in(1'b1),
    .carry_in(1'b0), .b_in(wd_b), .timer_done_in(wd_tdone),
    .init_out(wd_init), .a_set_out(wd_aset), .b_set_out(wd_bset),
    .cnt_set_out(wd_cset), .mux_sel_out(wd_mux), .timer_start_out(wd_tstart),
    .led_out(wd_led), .busy_out(wd_busy), .done_out(wd_done),
    .fault_out(wd_fault), .ovf_out(wd_ovf)
  );

  // ---------------- monitor (samples 1 time unit after posedge) ----------------
  int            n_init = 0, n_tstart = 0, n_done = 0;
  logic          tstart_d = 1'b0;
  logic [DW-1:0] led_log[$];
  logic          ovf_log[$];

  always @(posedge clk) begin
    #1;
    if (init_o === 1'b1) n_init++;
    if (tstart_o === 1'b1) n_tstart++;
    if (done_o === 1'b1) n_done++;
    if (tstart_d) begin
      led_log.push_back(led_o);
      ovf_log.push_back(ovf_o);
    end
    tstart_d = (tstart_o === 1'b1);
  end

  task automatic clear_mon();
    n_init = 0; n_tstart = 0; n_done = 0;
    led_log.delete(); ovf_log.delete();
  endtask

  // Returns at the negedge of the INIT cycle.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tdone = 1'b0; n_const = 4'd5;
    wd_start = 1'b0; wd_tdone = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL reset_outs: got %h required 0", outs); end
    checks++;
    if (wd_outs !== '0) begin errs++; $display("FAIL reset_wd_outs: got %h required 0", wd_outs); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL idle_after_reset: got %h required 0", outs); end
  endtask

  task automatic test_normal();
    int cyc;
    logic [DW-1:0] exp_led[6];
    logic [DW-1:0] got;
    exp_led = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8};
    n_const = 4'd5; tdone = 1'b1;
    clear_mon();
    pulse_start();
    checks++;
    if ({init_o, cnt_set_o, mux_o, busy_o, tstart_o} !== 5'b11010) begin
      errs++; $display("FAIL init_cycle: got %b required 11010", {init_o, cnt_set_o, mux_o, busy_o, tstart_o});
    end
    @(negedge clk);
    checks++;
    if ({tstart_o, init_o, busy_o} !== 3'b101) begin
      errs++; $display("FAIL show_cycle: got %b required 101", {tstart_o, init_o, busy_o});
    end
    cyc = 2;
    while (done_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== 25) begin errs++; $display("FAIL normal_done_cycle: got %0d required 25", cyc); end
    for (int i = 0; i < 6; i++) begin
      got = (i < led_log.size()) ? led_log[i] : 4'hx;
      checks++;
      if (got !== exp_led[i]) begin errs++; $display("FAIL normal_led[%0d]: got %h required %h", i, got, exp_led[i]); end
    end
    checks++;
    if (n_tstart !== 6) begin errs++; $display("FAIL normal_timer_starts: got %0d required 6", n_tstart); end
    checks++;
    if (n_done !== 1) begin errs++; $display("FAIL normal_done_count: got %0d required 1", n_done); end
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, ovf_o, led_o} !== {3'b000, 4'd8}) begin
      errs++; $display("FAIL normal_end_state: got %b required 0001000", {busy_o, done_o, ovf_o, led_o});
    end
  endtask

  task automatic test_handshake();
    int cyc;
    logic [DW-1:0] exp_led[3];
    exp_led = '{4'd1, 4'd1, 4'd2};
    n_const = 4'd2; tdone = 1'b0;
    clear_mon();
    pulse_start();
    for (int t = 0; t < 3; t++) begin
      cyc = 0;
      while (tstart_o !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      checks++;
      if (tstart_o !== 1'b1) begin errs++; $display("FAIL hs_show[%0d]: got %b required 1", t, tstart_o); end
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        checks++;
        if ({busy_o, a_set_o, done_o, fault_o, tstart_o} !== 5'b10000 || led_o !== exp_led[t]) begin
          errs++;
          $display("FAIL hs_hold[%0d.%0d]: got flags %b led %h required flags 10000 led %h",
                   t, i, {busy_o, a_set_o, done_o, fault_o, tstart_o}, led_o, exp_led[t]);
        end
      end
      tdone = 1'b1;
      @(negedge clk);
      tdone = 1'b0;
      @(negedge clk);
      checks++;
      if (t < 2) begin
        if ({a_set_o, b_set_o, cnt_set_o, mux_o} !== 4'b1111) begin
          errs++; $display("FAIL hs_step[%0d]: got %b required 1111", t, {a_set_o, b_set_o, cnt_set_o, mux_o});
        end
      end else begin
        if (done_o !== 1'b1) begin errs++; $display("FAIL hs_done: got %b required 1", done_o); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int cyc;
    logic [DW-1:0] exp_led[8];
    logic [DW-1:0] got;
    exp_led = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5};
    n_const = 4'd7; tdone = 1'b1;
    clear_mon();
    pulse_start();
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== 33) begin errs++; $display("FAIL ovf_done_cycle: got %0d required 33", cyc); end
    for (int i = 0; i < 8; i++) begin
      got = (i < led_log.size()) ? led_log[i] : 4'hx;
      checks++;
      if (got !== exp_led[i]) begin errs++; $display("FAIL ovf_led[%0d]: got %h required %h", i, got, exp_led[i]); end
    end
    checks++;
    if (ovf_log.size() != 8 || ovf_log[6] !== 1'b0 || ovf_log[7] !== 1'b1) begin
      errs++; $display("FAIL ovf_timing: got %0d entries, term7/term8 flags %b%b required 01",
                       ovf_log.size(), (ovf_log.size() > 6) ? ovf_log[6] : 1'bx, (ovf_log.size() > 7) ? ovf_log[7] : 1'bx);
    end
    @(negedge clk);
    checks++;
    if ({ovf_o, busy_o, led_o} !== {2'b10, 4'd5}) begin
      errs++; $display("FAIL ovf_end_state: got %b required 105", {ovf_o, busy_o, led_o});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    n_const = 4'd5; tdone = 1'b1;
    clear_mon();
    pulse_start();
    @(negedge clk);
    cyc = 2;
    checks++;
    if (ovf_o !== 1'b0) begin errs++; $display("FAIL b2b_ovf_cleared: got %b required 0", ovf_o); end
    while (cyc < 20) begin start = cyc[0]; @(negedge clk); cyc++; end
    start = 1'b1;
    while (done_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== 25) begin errs++; $display("FAIL b2b_done_cycle: got %0d required 25", cyc); end
    checks++;
    if (n_init !== 1) begin errs++; $display("FAIL b2b_ignored_start: got %0d inits required 1", n_init); end
    @(negedge clk);
    checks++;
    if ({busy_o, init_o} !== 2'b00) begin errs++; $display("FAIL b2b_idle: got %b required 00", {busy_o, init_o}); end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({init_o, busy_o} !== 2'b11) begin errs++; $display("FAIL b2b_retrigger: got %b required 11", {init_o, busy_o}); end
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    n_const = 4'd5; tdone = 1'b1;
    clear_mon();
    pulse_start();
    cyc = 1;
    while (n_tstart < 3 && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    checks++;
    if ({busy_o, led_o} !== {1'b1, 4'd2}) begin
      errs++; $display("FAIL rmid_pre: got busy %b led %h required busy 1 led 2", busy_o, led_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL rmid_async: got %h required 0", outs); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL rmid_idle: got %h required 0", outs); end
  endtask

  task automatic test_watchdog();
    @(negedge clk); wd_start = 1'b1;
    @(negedge clk); wd_start = 1'b0;
    @(negedge clk);
    checks++;
    if (wd_tstart !== 1'b1) begin errs++; $display("FAIL wd_show: got %b required 1", wd_tstart); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if ({wd_fault, wd_busy} !== 2'b01) begin
        errs++; $display("FAIL wd_wait[%0d]: got %b required 01", i, {wd_fault, wd_busy});
      end
    end
    @(negedge clk);
    checks++;
    if ({wd_fault, wd_busy, wd_led} !== {2'b10, 4'd1}) begin
      errs++; $display("FAIL wd_fault: got %b required 100001", {wd_fault, wd_busy, wd_led});
    end
    @(negedge clk);
    wd_start = 1'b1;
    checks++;
    if ({wd_fault, wd_led} !== {1'b1, 4'd1}) begin
      errs++; $display("FAIL wd_fault_hold: got %b required 10001", {wd_fault, wd_led});
    end
    @(negedge clk);
    wd_start = 1'b0;
    checks++;
    if ({wd_init, wd_fault, wd_busy} !== 3'b101) begin
      errs++; $display("FAIL wd_restart: got %b required 101", {wd_init, wd_fault, wd_busy});
    end
  endtask

  // Continues from the INIT cycle left by test_watchdog.
  task automatic test_tie();
    @(negedge clk);
    checks++;
    if (wd_tstart !== 1'b1) begin errs++; $display("FAIL tie_show: got %b required 1", wd_tstart); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) wd_tdone = 1'b1;
    end
    @(negedge clk);
    wd_tdone = 1'b0;
    checks++;
    if ({wd_fault, wd_busy, wd_done} !== 3'b010) begin
      errs++; $display("FAIL tie_check: got %b required 010", {wd_fault, wd_busy, wd_done});
    end
    @(negedge clk);
    checks++;
    if ({wd_done, wd_fault} !== 2'b10) begin
      errs++; $display("FAIL tie_done: got %b required 10", {wd_done, wd_fault});
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_handshake();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_watchdog();
    test_tie();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
